// File: rtl/mem_port_arbiter_if.sv
// Master-side bus port of mem_port_arbiter: request/grant handshake plus the
// read-response channel routed back to the issuing master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of one synchronous-read memory: one command per
// cycle, read responses steered back to their owner after RD_LAT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    mem_port_arbiter_if.slave m0,
    mem_port_arbiter_if.slave m1,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              busy
);
    localparam int NUM_PORTS = 2;

    logic [NUM_PORTS-1:0]             req, we, gnt, rvalid;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;

    logic              last, sel, any_req, issue_rd, issue_wr;
    logic [RD_LAT-1:0] vld_pipe, own_pipe;

    // Gating req with reset keeps every combinational command output at 0 in reset.
    assign req   = {m1.req, m0.req} & {NUM_PORTS{n_rst}};
    assign we    = {m1.we, m0.we};
    assign addr  = {m1.addr, m0.addr};
    assign wdata = {m1.wdata, m0.wdata};

    always_comb begin
        any_req = |req;
        if (&req) sel = (PRIO_MODE != 0) ? 1'b0 : ~last;
        else      sel = ~req[0];
        gnt = '0;
        if (any_req) gnt[sel] = 1'b1;
        issue_rd   = any_req & ~we[sel];
        issue_wr   = any_req & we[sel];
        mem_r_en   = issue_rd;
        mem_r_addr = issue_rd ? addr[sel] : '0;
        mem_w_en   = issue_wr;
        mem_w_addr = issue_wr ? addr[sel] : '0;
        mem_w_data = issue_wr ? wdata[sel] : '0;
    end

    // Valid/owner shift pipeline mirrors the memory read latency.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last     <= 1'b1;
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            if (any_req) last <= sel;
            vld_pipe[0] <= issue_rd;
            own_pipe[0] <= sel;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
        assign rvalid[p] = vld_pipe[RD_LAT-1] & (own_pipe[RD_LAT-1] == 1'(p));
    end

    assign m0.gnt    = gnt[0];
    assign m0.rvalid = rvalid[0];
    assign m0.rdata  = rvalid[0] ? mem_r_data : '0;
    assign m1.gnt    = gnt[1];
    assign m1.rvalid = rvalid[1];
    assign m1.rdata  = rvalid[1] ? mem_r_data : '0;
    assign busy      = |vld_pipe;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three configurations (RR lat1, RR lat3, fixed
// priority lat1), each with a behavioural memory; reads tracked on a scoreboard.
module tb_mem_port_arbiter;
    localparam int NDUT = 3;

    logic clk, n_rst;
    logic [NDUT-1:0][1:0]       req, we, gnt, rvalid;
    logic [NDUT-1:0][1:0][31:0] addr, wdata, rdata;
    logic [NDUT-1:0]            r_en, w_en, busy;
    logic [NDUT-1:0][31:0]      r_addr, w_addr, w_data, r_data;

    typedef struct {
        int          m;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        sbq[$];
    logic [31:0] shadow [NDUT][256];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cur    = 0;
    bit          mon_en = 0;

    function automatic logic [31:0] base_word(input logic [7:0] a);
        return (a == 8'h10) ? 32'hCAFEBABE : (32'h1000_0000 | {24'h0, a});
    endfunction

    function automatic int lat_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        localparam int L = (d == 1) ? 3 : 1;

        mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
        mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

        assign m0_if.req   = req[d][0];
        assign m0_if.we    = we[d][0];
        assign m0_if.addr  = addr[d][0];
        assign m0_if.wdata = wdata[d][0];
        assign m1_if.req   = req[d][1];
        assign m1_if.we    = we[d][1];
        assign m1_if.addr  = addr[d][1];
        assign m1_if.wdata = wdata[d][1];
        assign gnt[d][0]    = m0_if.gnt;
        assign rvalid[d][0] = m0_if.rvalid;
        assign rdata[d][0]  = m0_if.rdata;
        assign gnt[d][1]    = m1_if.gnt;
        assign rvalid[d][1] = m1_if.rvalid;
        assign rdata[d][1]  = m1_if.rdata;

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .RD_LAT(L), .PRIO_MODE((d == 2) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .n_rst      (n_rst),
            .m0         (m0_if),
            .m1         (m1_if),
            .mem_r_en   (r_en[d]),
            .mem_r_addr (r_addr[d]),
            .mem_r_data (r_data[d]),
            .mem_w_en   (w_en[d]),
            .mem_w_addr (w_addr[d]),
            .mem_w_data (w_data[d]),
            .busy       (busy[d])
        );

        // Memory model: unwritten words read as base_word(addr).
        logic [31:0]  mem [256];
        logic [255:0] wr_vld = '0;
        logic [31:0]  rpipe [L];

        always @(posedge clk) begin
            if (w_en[d]) begin
                mem[w_addr[d][7:0]]    <= w_data[d];
                wr_vld[w_addr[d][7:0]] <= 1'b1;
            end
            if (r_en[d])
                rpipe[0] <= wr_vld[r_addr[d][7:0]] ? mem[r_addr[d][7:0]] : base_word(r_addr[d][7:0]);
            for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
        end
        assign r_data[d] = rpipe[L-1];
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor: each scoreboard entry must appear exactly on its due cycle.
    always @(negedge clk) begin
        rsp_t e;
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++)
                if (d != cur) chk("idle_rvalid", 32'(rvalid[d]), 32'd0);
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("rv_owner", 32'(rvalid[cur]), 32'(1) << e.m);
                chk("rdata", rdata[cur][e.m], e.data);
            end else begin
                chk("rv_none", 32'(rvalid[cur]), 32'd0);
            end
            for (int m = 0; m < 2; m++)
                if (!rvalid[cur][m]) chk("rdata_zero", rdata[cur][m], 32'd0);
        end
    end

    // One issue cycle: drive, check grant/command at negedge, log expected response.
    task automatic drive(input int d, input logic [1:0] rq, input logic [1:0] wr,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] exp_g, input int exp_busy);
        int          g;
        logic        exp_ren, exp_wen;
        logic [7:0]  ea;
        logic [31:0] ed;
        req[d] = rq;  we[d] = wr;
        addr[d][0] = {24'h0, a0};  addr[d][1] = {24'h0, a1};
        wdata[d][0] = d0;  wdata[d][1] = d1;
        @(negedge clk);
        g  = exp_g[1] ? 1 : 0;
        ea = g ? a1 : a0;
        ed = g ? d1 : d0;
        exp_ren = (exp_g != 2'b00) && !wr[g];
        exp_wen = (exp_g != 2'b00) && wr[g];
        chk("gnt", 32'(gnt[d]), 32'(exp_g));
        chk("mem_r_en", 32'(r_en[d]), 32'(exp_ren));
        chk("mem_r_addr", r_addr[d], exp_ren ? {24'h0, ea} : 32'h0);
        chk("mem_w_en", 32'(w_en[d]), 32'(exp_wen));
        chk("mem_w_addr", w_addr[d], exp_wen ? {24'h0, ea} : 32'h0);
        chk("mem_w_data", w_data[d], exp_wen ? ed : 32'h0);
        if (exp_busy >= 0) chk("busy", 32'(busy[d]), 32'(exp_busy));
        if (exp_ren) sbq.push_back('{g, shadow[d][ea], cyc + lat_of(d)});
        if (exp_wen) shadow[d][ea] = ed;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d, input int exp_busy);
        drive(d, 2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 2'b00, exp_busy);
    endtask

    initial begin
        int n0, n1;
        clk = 0;  n_rst = 1;
        req = '0;  we = '0;  addr = '0;  wdata = '0;
        for (int d = 0; d < NDUT; d++)
            for (int a = 0; a < 256; a++) shadow[d][a] = base_word(8'(a));

        // Reset: outputs forced low even with requests pending.
        #1 n_rst = 0;
        for (int d = 0; d < NDUT; d++) req[d] = 2'b11;
        #2;
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_gnt", 32'(gnt[d]), 32'd0);
            chk("rst_r_en", 32'(r_en[d]), 32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        req = '0;
        n_rst = 1;
        mon_en = 1;

        // Round-robin fairness from reset.
        cur = 0;  n0 = 0;  n1 = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 2'b11, 2'b00, 8'(8'h40 + n0), 8'(8'h80 + n1), 32'h0, 32'h0,
                  (i % 2 == 0) ? 2'b01 : 2'b10, (i == 0) ? 0 : 1);
            if (i % 2 == 0) n0++; else n1++;
        end
        idle(0, 1);
        idle(0, 0);

        // Single read of the preset word.
        drive(0, 2'b01, 2'b00, 8'h10, 8'h0, 32'h0, 32'h0, 2'b01, 0);
        idle(0, 1);
        idle(0, 0);

        // Write then read of the same address, then a read/write tie.
        drive(0, 2'b10, 2'b10, 8'h0, 8'h20, 32'h0, 32'h12345678, 2'b10, 0);
        drive(0, 2'b01, 2'b00, 8'h20, 8'h0, 32'h0, 32'h0, 2'b01, 0);
        idle(0, 1);
        idle(0, 0);
        drive(0, 2'b11, 2'b01, 8'h30, 8'h30, 32'hDEADBEEF, 32'h0, 2'b10, 0);
        drive(0, 2'b01, 2'b01, 8'h30, 8'h30, 32'hDEADBEEF, 32'h0, 2'b01, 1);
        drive(0, 2'b10, 2'b00, 8'h0, 8'h30, 32'h0, 32'h0, 2'b10, 0);
        idle(0, 1);
        idle(0, 0);

        // Fixed priority: m0 wins every tie, m1 only once m0 drops.
        cur = 2;
        for (int i = 0; i < 4; i++)
            drive(2, 2'b11, 2'b00, 8'(8'h50 + i), 8'h90, 32'h0, 32'h0, 2'b01, (i == 0) ? 0 : 1);
        drive(2, 2'b10, 2'b00, 8'h0, 8'h90, 32'h0, 32'h0, 2'b10, 1);
        idle(2, 1);
        idle(2, 0);

        // RD_LAT=3: four alternating back-to-back reads.
        cur = 1;  n0 = 0;  n1 = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b11, 2'b00, 8'(8'h60 + n0), 8'(8'hA0 + n1), 32'h0, 32'h0,
                  (i % 2 == 0) ? 2'b01 : 2'b10, (i == 0) ? 0 : 1);
            if (i % 2 == 0) n0++; else n1++;
        end
        idle(1, 1);
        idle(1, 1);
        idle(1, 1);
        idle(1, 0);

        // Reset one cycle after a read grant: response discarded, last back to 1.
        drive(1, 2'b01, 2'b00, 8'h70, 8'h0, 32'h0, 32'h0, 2'b01, 0);
        n_rst = 0;
        sbq.delete();
        req[1] = 2'b11;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy[1]), 32'd0);
        chk("mid_rst_gnt", 32'(gnt[1]), 32'd0);
        chk("mid_rst_r_en", 32'(r_en[1]), 32'd0);
        @(posedge clk); #1;
        req[1] = 2'b00;
        n_rst = 1;
        for (int i = 0; i < 4; i++) idle(1, 0);
        drive(1, 2'b11, 2'b00, 8'h71, 8'hB0, 32'h0, 32'h0, 2'b01, 0);
        req[1] = 2'b00;
        idle(1, 1);
        idle(1, 1);
        idle(1, 1);
        idle(1, 0);

        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
